pipe_hazard_ctrl: RTL

- Parametrised pipeline control unit for the 5-stage core; the next generation of the fixed, hazard-blind pipeline.
- Tracks in-flight destination registers through NSTAGES post-decode stages (default EXE, MEM, WB).
- Generates stall, bubble and flush controls and per-operand forwarding selects.
- Keeps saturating stall and flush counters.
- Sits beside ID; drives the PC, IF_ID and ID_EXE enables and the EXE operand muxes.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-side hazard unit for the 5-stage core.
// Tracks in-flight destinations after ID, detects RAW hazards and produces
// stall / bubble / flush controls, EXE forwarding selects and event counters.
module pipe_hazard_ctrl #(
   parameter  int unsigned RFW       = 5,
   parameter  int unsigned NSTAGES   = 3,
   parameter  int unsigned FWD_EN    = 1,
   parameter  int unsigned WB_BYPASS = 1,
   parameter  int unsigned CNTW      = 16,
   localparam int unsigned SELW      = $clog2(NSTAGES + 1)
) (
   input  logic            clk,
   input  logic            start,
   input  logic            id_valid,
   input  logic [RFW-1:0]  id_rs1,
   input  logic [RFW-1:0]  id_rs2,
   input  logic            id_use1,
   input  logic            id_use2,
   input  logic [RFW-1:0]  id_rd,
   input  logic            id_we,
   input  logic            id_is_load,
   input  logic            exe_redirect,
   output logic            pc_stall,
   output logic            if_id_stall,
   output logic            id_exe_bubble,
   output logic            if_id_flush,
   output logic [SELW-1:0] fwd1_sel,
   output logic [SELW-1:0] fwd2_sel,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] flush_cnt
);

   localparam logic [SELW-1:0] LAST_K = SELW'(NSTAGES - 1);

   // In-flight tracking entries: index 0 = EXE ... NSTAGES-1 = WB
   logic           r_v  [NSTAGES];
   logic [RFW-1:0] r_rd [NSTAGES];
   logic           r_we [NSTAGES];
   logic           r_ld [NSTAGES];

   logic [CNTW-1:0] r_stall_cnt;
   logic [CNTW-1:0] r_flush_cnt;

   // Per-operand view of the ID sources (0 = rs1, 1 = rs2)
   logic           w_use    [2];
   logic [RFW-1:0] w_rs     [2];
   logic           w_hit    [2];
   logic           w_hit_ld [2];
   logic [SELW-1:0] w_k     [2];
   logic           w_haz    [2];
   logic [SELW-1:0] w_sel   [2];

   logic w_stall;
   logic w_redir;
   logic w_issue;

   assign w_use[0] = id_use1;
   assign w_use[1] = id_use2;
   assign w_rs[0]  = id_rs1;
   assign w_rs[1]  = id_rs2;

   // Youngest matching entry per operand; oldest-first scan so younger hits overwrite
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         w_hit[n]    = 1'b0;
         w_hit_ld[n] = 1'b0;
         w_k[n]      = '0;
         for (int k = int'(NSTAGES) - 1; k >= 0; k--) begin
            if (w_use[n] && (w_rs[n] != '0) && r_v[k] && r_we[k] && (r_rd[k] == w_rs[n])) begin
               w_hit[n]    = 1'b1;
               w_hit_ld[n] = r_ld[k];
               w_k[n]      = SELW'(k);
            end
         end
      end
   end

   // Hazard and forwarding decision per operand
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         w_haz[n] = 1'b0;
         w_sel[n] = '0;
         if (w_hit[n]) begin
            if (FWD_EN != 0) begin
               // load result exists only after MEM: a load in EXE costs one bubble
               w_haz[n] = (w_k[n] == '0) && w_hit_ld[n];
               if (w_k[n] == LAST_K) begin
                  w_sel[n] = (WB_BYPASS != 0) ? '0 : SELW'(NSTAGES);
               end else begin
                  w_sel[n] = w_k[n] + SELW'(1);
               end
            end else begin
               w_haz[n] = (w_k[n] != LAST_K) || (WB_BYPASS == 0);
            end
         end
      end
   end

   assign w_stall = id_valid & (w_haz[0] | w_haz[1]) & ~start;
   assign w_redir = exe_redirect & ~start;
   assign w_issue = id_valid & ~w_stall & ~w_redir;

   // Redirect wins over stall; start silences everything
   assign pc_stall      = w_stall & ~w_redir;
   assign if_id_stall   = w_stall & ~w_redir;
   assign id_exe_bubble = w_stall | w_redir;
   assign if_id_flush   = w_redir;
   assign fwd1_sel      = start ? '0 : w_sel[0];
   assign fwd2_sel      = start ? '0 : w_sel[1];
   assign stall_cnt     = r_stall_cnt;
   assign flush_cnt     = r_flush_cnt;

   // Shift the tracking entries; entry 0 takes the issuing instruction or a bubble
   always_ff @(posedge clk) begin
      if (start) begin
         for (int k = 0; k < int'(NSTAGES); k++) begin
            r_v[k]  <= 1'b0;
            r_rd[k] <= '0;
            r_we[k] <= 1'b0;
            r_ld[k] <= 1'b0;
         end
      end else begin
         for (int k = 1; k < int'(NSTAGES); k++) begin
            r_v[k]  <= r_v[k-1];
            r_rd[k] <= r_rd[k-1];
            r_we[k] <= r_we[k-1];
            r_ld[k] <= r_ld[k-1];
         end
         r_v[0]  <= w_issue;
         r_rd[0] <= id_rd;
         r_we[0] <= id_we;
         r_ld[0] <= id_is_load;
      end
   end

   // Saturating stall / flush event counters
   always_ff @(posedge clk) begin
      if (start) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
         end
         if (w_redir && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNTW'(1);
         end
      end
   end

endmodule
